// File: rtl/demapper_if.sv
// Line-side, payload-side and status signals of the frame demapper.
`timescale 1ns/1ps
interface demapper_if;
  logic [7:0] i_frame_data;
  logic       i_frame_data_valid;
  logic       i_frame_data_fas;
  logic [7:0] o_pyld_data;
  logic       o_pyld_data_valid;
  logic       o_pyld_data_last;
  logic       i_pyld_fifo_ready;
  logic       o_lock;
  logic [7:0] o_oh_byte;
  logic [7:0] o_crc_val;
  logic       o_crc_err;
  logic       o_crc_err_valid;
  logic       o_retrans_req;
  logic       o_pyld_ovf;
  logic       i_arq_en;

  // driver of the line and client side (bench or upstream logic)
  modport master (
    output i_frame_data, i_frame_data_valid, i_frame_data_fas,
    output i_pyld_fifo_ready, i_arq_en,
    input  o_pyld_data, o_pyld_data_valid, o_pyld_data_last,
    input  o_lock, o_oh_byte, o_crc_val, o_crc_err, o_crc_err_valid,
    input  o_retrans_req, o_pyld_ovf
  );

  // the demapper itself
  modport slave (
    input  i_frame_data, i_frame_data_valid, i_frame_data_fas,
    input  i_pyld_fifo_ready, i_arq_en,
    output o_pyld_data, o_pyld_data_valid, o_pyld_data_last,
    output o_lock, o_oh_byte, o_crc_val, o_crc_err, o_crc_err_valid,
    output o_retrans_req, o_pyld_ovf
  );
endinterface

// File: rtl/demapper.sv
// Frame demapper: aligns on the F6/28 pattern, extracts overhead and payload
// from a 4 x COLS frame, and checks the trailing CRC-8.
`timescale 1ns/1ps
module demapper #(
  parameter int         COLS     = 1024,
  parameter logic [7:0] CRC_POLY = 8'h07
) (
  input  logic      i_clk,
  input  logic      i_rst,
  demapper_if.slave dif
);

  // state | meaning
  // HUNT  | searching for F6 flagged as frame start
  // FAS2  | F6 seen, the next valid byte must be 28
  // LOCK  | aligned; overhead, payload and CRC are processed
  typedef enum logic [1:0] {HUNT, FAS2, LOCK} state_t;

  localparam logic [10:0] LAST_COL     = 11'(COLS - 1);
  localparam logic [10:0] PRE_LAST_COL = 11'(COLS - 2);
  localparam logic [7:0]  FAS_A        = 8'hF6;
  localparam logic [7:0]  FAS_B        = 8'h28;

  state_t      state, state_nxt;
  logic [1:0]  row, row_nxt, row_inc;
  logic [10:0] col, col_nxt, col_inc;
  logic        proc;
  logic        sof, at_start, is_fas1, is_oh, is_crc, is_last, is_pyld;

  logic [7:0]  crc_acc;
  logic [7:0]  pyld_data, oh_byte, crc_val;
  logic        pyld_valid, pyld_last, crc_err, crc_err_valid, retrans_req, pyld_ovf;

  function automatic logic [7:0] crc8_byte(input logic [7:0] crc, input logic [7:0] d);
    logic [7:0] c;
    c = crc ^ d;
    for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ CRC_POLY) : (c << 1);
    return c;
  endfunction

  // Position the incoming byte occupies if alignment still holds
  always_comb begin
    row_inc = row;
    col_inc = col + 11'd1;
    if (col == LAST_COL) begin
      col_inc = '0;
      row_inc = row + 2'd1;
    end
  end

  assign sof      = dif.i_frame_data_fas && (dif.i_frame_data == FAS_A);
  assign at_start = (row_inc == 2'd0) && (col_inc == 11'd0);
  assign is_fas1  = (row_inc == 2'd0) && (col_inc == 11'd1);
  assign is_oh    = (row_inc == 2'd0) && (col_inc == 11'd2);
  assign is_crc   = (row_inc == 2'd3) && (col_inc == LAST_COL);
  assign is_last  = (row_inc == 2'd3) && (col_inc == PRE_LAST_COL);
  assign is_pyld  = !is_fas1 && !is_oh && !is_crc;

  // Next-state and alignment bookkeeping; proc marks a byte processed in lock
  always_comb begin
    state_nxt = state;
    row_nxt   = row;
    col_nxt   = col;
    proc      = 1'b0;
    if (dif.i_frame_data_valid) begin
      case (state)
        HUNT: begin
          if (sof) begin
            state_nxt = FAS2;
            row_nxt   = '0;
            col_nxt   = '0;
          end
        end
        FAS2: begin
          if (dif.i_frame_data == FAS_B) begin
            state_nxt = LOCK;
            row_nxt   = '0;
            col_nxt   = 11'd1;
          end else begin
            state_nxt = HUNT;
          end
        end
        LOCK: begin
          if (at_start) begin
            // a good frame start keeps lock; anything else drops it
            row_nxt = '0;
            col_nxt = '0;
            if (!sof) state_nxt = HUNT;
          end else if (dif.i_frame_data_fas) begin
            // stray frame-start marker: re-hunt, reusing this byte if it is F6
            row_nxt   = '0;
            col_nxt   = '0;
            state_nxt = (dif.i_frame_data == FAS_A) ? FAS2 : HUNT;
          end else begin
            row_nxt = row_inc;
            col_nxt = col_inc;
            proc    = 1'b1;
          end
        end
        default: state_nxt = HUNT;
      endcase
    end
  end

  // State and frame position registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= HUNT;
      row   <= '0;
      col   <= '0;
    end else begin
      state <= state_nxt;
      row   <= row_nxt;
      col   <= col_nxt;
    end
  end

  // Overhead capture, payload forwarding and CRC accumulate/compare
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      crc_acc       <= '0;
      pyld_data     <= '0;
      pyld_valid    <= 1'b0;
      pyld_last     <= 1'b0;
      oh_byte       <= '0;
      crc_val       <= '0;
      crc_err       <= 1'b0;
      crc_err_valid <= 1'b0;
      retrans_req   <= 1'b0;
      pyld_ovf      <= 1'b0;
    end else begin
      pyld_valid    <= 1'b0;
      pyld_last     <= 1'b0;
      crc_err_valid <= 1'b0;
      retrans_req   <= 1'b0;
      if (dif.i_frame_data_valid) begin
        if (!proc) begin
          // outside lock or at a frame boundary any partial CRC is discarded
          crc_acc <= '0;
        end else if (is_crc) begin
          crc_val       <= crc_acc;
          crc_err       <= (crc_acc != dif.i_frame_data);
          crc_err_valid <= 1'b1;
          retrans_req   <= (crc_acc != dif.i_frame_data) && dif.i_arq_en;
          crc_acc       <= '0;
        end else if (!is_fas1) begin
          crc_acc <= crc8_byte(crc_acc, dif.i_frame_data);
          if (is_oh) oh_byte <= dif.i_frame_data;
          if (is_pyld) begin
            if (dif.i_pyld_fifo_ready) begin
              pyld_data  <= dif.i_frame_data;
              pyld_valid <= 1'b1;
              pyld_last  <= is_last;
            end else begin
              pyld_ovf <= 1'b1;
            end
          end
        end
      end
    end
  end

  assign dif.o_lock            = (state == LOCK);
  assign dif.o_pyld_data       = pyld_data;
  assign dif.o_pyld_data_valid = pyld_valid;
  assign dif.o_pyld_data_last  = pyld_last;
  assign dif.o_oh_byte         = oh_byte;
  assign dif.o_crc_val         = crc_val;
  assign dif.o_crc_err         = crc_err;
  assign dif.o_crc_err_valid   = crc_err_valid;
  assign dif.o_retrans_req     = retrans_req;
  assign dif.o_pyld_ovf        = pyld_ovf;

endmodule

// File: doc/demapper.md
DEMAPPER -- requirements
Module: demapper

Interface
REQ-001 SHALL have parameter COLS, default 1024, columns per row (frame = 4 rows x COLS bytes, row-major).
REQ-002 SHALL have parameter CRC_POLY, default 8'h07, CRC-8 generator polynomial.
REQ-003 i_clk  in  1  single clock; all logic on rising edge.
REQ-004 i_rst  in  1  reset, asynchronous, active-high.
REQ-005 i_frame_data  in  8  line byte from serial receiver.
REQ-006 i_frame_data_valid  in  1  line byte qualifier; line cannot be stalled.
REQ-007 i_frame_data_fas  in  1  upstream marker: this byte is frame start (row 0 col 0).
REQ-008 o_pyld_data  out  8  extracted payload byte to client FIFO.
REQ-009 o_pyld_data_valid  out  1  payload byte qualifier (AXIS valid).
REQ-010 o_pyld_data_last  out  1  marks last payload byte of a frame.
REQ-011 i_pyld_fifo_ready  in  1  client FIFO can accept a byte.
REQ-012 o_lock  out  1  frame alignment held.
REQ-013 o_oh_byte  out  8  overhead byte of most recent frame.
REQ-014 o_crc_val  out  8  computed CRC of most recent completed frame.
REQ-015 o_crc_err / o_crc_err_valid  out  1/1  CRC compare result and 1-cycle strobe.
REQ-016 o_retrans_req  out  1  one-cycle retransmission request pulse.
REQ-017 o_pyld_ovf  out  1  sticky: payload byte dropped because client FIFO not ready.
REQ-018 i_arq_en  in  1  enables retransmission requests.

Function
REQ-019 Frame layout SHALL be: row0 col0 = 8'hF6, row0 col1 = 8'h28 (FAS); row0 col2 = overhead; row3 col COLS-1 = CRC; all other positions payload (4*COLS-4 bytes).
REQ-020 Row counter (2 bit) and column counter (11 bit) SHALL advance only on i_frame_data_valid; col wraps COLS-1 -> 0 incrementing row; row wraps 3 -> 0.
REQ-021 FSM states SHALL be HUNT, FAS2, LOCK.
REQ-022 HUNT -> FAS2 on valid & fas & data==F6; counters set to row0 col0 for that byte.
REQ-023 FAS2 -> LOCK on next valid byte == 28; any other valid byte -> HUNT.
REQ-024 LOCK -> HUNT when the byte at row0 col0 lacks fas or is not F6, or when fas is asserted at any other position; the offending byte with fas & F6 SHALL immediately re-enter FAS2 (same-cycle re-hunt).
REQ-025 o_lock SHALL be 1 only in LOCK; payload, overhead and CRC processing occur only in LOCK.
REQ-026 Payload byte accepted in cycle N SHALL appear on o_pyld_data with o_pyld_data_valid=1 in cycle N+1; o_pyld_data_last=1 for row3 col COLS-2.
REQ-027 If i_pyld_fifo_ready=0 in cycle N for a payload byte, the byte SHALL be dropped, valid stays 0, o_pyld_ovf set until reset.
REQ-028 o_oh_byte SHALL update one cycle after row0 col2 is accepted.
REQ-029 CRC-8: init 8'h00, MSB-first, CRC_POLY, no reflection/XOR-out; covers row0 col2 through row3 col COLS-2 inclusive; FAS and CRC bytes excluded.
REQ-030 One cycle after the CRC byte is accepted: o_crc_val = computed CRC, o_crc_err = (computed != received), o_crc_err_valid = 1 for one cycle; CRC accumulator re-inits to 0.
REQ-031 o_retrans_req SHALL pulse in the same cycle as o_crc_err_valid when o_crc_err=1 and i_arq_en=1; never otherwise.
REQ-032 Loss of lock mid-frame SHALL discard the partial CRC (no o_crc_err_valid) and stop payload output the following cycle.
REQ-033 Invalid cycles SHALL hold all state; strobes deassert.

Reset
REQ-034 On i_rst (asynchronous, any time including mid-frame): FSM = HUNT, counters 0, CRC accumulator 0, all outputs 0 including o_pyld_ovf, o_crc_val, o_oh_byte.
REQ-035 After i_rst deasserts, the first byte SHALL be processed per HUNT rules.

Verification
REQ-036 Clean frame, COLS=1024, continuous valid, ready=1 -> o_lock=1 from byte 2; 4092 payload bytes in order, last flagged; o_crc_err_valid=1, o_crc_err=0, no retrans.
REQ-037 Same frame with one payload bit flipped, i_arq_en=1 -> o_crc_err=1, o_retrans_req single pulse; with i_arq_en=0 -> no pulse.
REQ-038 F6 with fas followed by 8'h29 -> returns HUNT, o_lock never 1, no payload output.
REQ-039 fas asserted at row1 col5 while locked -> o_lock=0, no CRC strobe for that frame; relock if next byte is 28.
REQ-040 i_pyld_fifo_ready=0 for 3 payload bytes -> exactly those 3 missing from output, o_pyld_ovf=1 persists; random valid gaps -> output unchanged except timing.
REQ-041 i_rst asserted mid-frame -> all outputs 0 asynchronously; next full frame processed normally.
